axis_palette_lut_mp: RTL and testbench
======================================

// Module: axis_palette_lut_mp
// PURPOSE
//  Multi-palette, parametrised successor to the video palette LUT. Unpacks LANES pixel indices per input beat,
//  looks up each in a PALETTES x 2^PIX_WIDTH colour RAM, and emits one OUT_WIDTH colour per output beat.
//  Palette is selected per frame (latched at SOF) from pal_sel, or auto-alternated in toggle mode.
//  Sits between the AGC/pixel-index stream and the video output path; LUT RAM is loaded by the CPU through a same-clock RAM port.
// PARAMETERS
//  PIX_WIDTH  8   pixel index width; palette entries = 2^PIX_WIDTH
//  LANES      4   pixel indices per s_axis beat (>=1)
//  PALETTES   4   number of palettes; power of 2, >=2
//  OUT_WIDTH  32  colour word width (m_axis_tdata, LUT words)
//  Derived: PAL_W=clog2(PALETTES), ADDR_W=PAL_W+PIX_WIDTH
// PORTS
//  axis_aclk      in   1                  clock for all logic, incl. LUT port
//  axis_aresetn   in   1                  reset, synchronous, active-low
//  pal_sel        in   PAL_W              requested palette, sampled at SOF
//  toggle_en      in   1                  toggle mode: alternate palette pal_act^1 every frame
//  s_axis_tdata   in   LANES*PIX_WIDTH    packed indices, lane 0 in LSBs, lane 0 output first
//  s_axis_tuser   in   LANES              per-lane SOF flag
//  s_axis_tvalid  in   1 / s_axis_tready out 1
//  m_axis_tdata   out  OUT_WIDTH          colour
//  m_axis_tuser   out  1                  SOF of this pixel
//  m_axis_tvalid  out  1 / m_axis_tready in 1
//  lut_en         in   1                  LUT port enable
//  lut_we         in   1                  LUT write (with lut_en)
//  lut_addr       in   ADDR_W             word address {palette, index}
//  lut_wdata      in   OUT_WIDTH          write data
//  lut_rdata      out  OUT_WIDTH          read data, latency 1, read-first
// BEHAVIOUR
//  Reset (axis_aresetn=0 at edge): m_axis_tvalid=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0, lut_rdata=0,
//   lane counter=0, holding reg empty, pal_act=0, toggle_armed=0. RAM contents unaffected. In-flight pixels dropped.
//  Pipeline advance: adv = ~m_axis_tvalid | m_axis_tready; all stages incl. RAM stream-port enable move only on adv.
//  Serialiser: holding reg takes beat when s_axis_tvalid & s_axis_tready; s_axis_tready = ~hold_valid |
//   (lane==LANES-1 & adv). Issues one lane per adv cycle, lane 0..LANES-1; counter wraps to 0 after last lane.
//  Stages: issue (RAM addr) -> RAM read (1 cycle) -> output reg. Beat accepted at edge E: lane k visible on m_axis
//   after edge E+2+k (no stall). Sustained 1 pixel/cycle; 1 beat per LANES cycles; no bubbles between beats.
//  m_axis_tdata/tuser held stable while m_axis_tvalid & ~m_axis_tready. No drop/duplicate under any backpressure.
//  Palette: on issue of a lane with SOF=1: if toggle_en & toggle_armed: pal_act <= pal_act^1, else pal_act <= pal_sel;
//   toggle_armed <= toggle_en. The SOF pixel itself uses the new value; non-SOF pixels use pal_act. Read addr = {pal, index}.
//  pal_sel/toggle_en changes mid-frame have no effect until next SOF. Multiple SOF lanes in one beat applied in lane order.
//  LUT port: single-clock true dual port; lut_rdata = mem[lut_addr] of previous cycle's lut_en access (read-first on write).
//  Collision (CPU write and stream read same address same cycle): stream gets old word; next read gets new word.
//  lut_rdata holds when lut_en=0.
// TESTING
//  1 Load pal0[i]={8'h0,i,i,i}; beat 0x03020100 tuser=4'b0001, pal_sel=0, m_ready=1 -> 0x000000,0x010101,0x020202,
//    0x030303, tuser 1,0,0,0, first valid after edge E+2, consecutive cycles.
//  2 pal2[i]=32'hAA0000|i; switch pal_sel 0->2 mid-frame -> remaining frame stays pal0; next SOF pixel idx 5 -> 0xAA0005.
//  3 toggle_en=1, pal_sel=2 over 4 frames -> palettes 2,3,2,3; drop toggle_en, pal_sel=1 -> next frame palette 1.
//  4 64 beats of random indices, m_axis_tready random 50% -> output == model sequence, data stable when stalled,
//    s_axis_tready never high with holding reg busy before last lane.
//  5 CPU write addr 0x005 = 0xDEADBEEF same cycle stream reads pal0 idx 5 -> stream sees old; next pixel idx 5 -> 0xDEADBEEF;
//    lut_rdata readback 0xDEADBEEF one cycle after read.
//  6 Assert reset mid-beat with m_axis stalled -> m_axis_tvalid=0 after edge, s_axis_tready=0 during reset, pal_act=0,
//    first post-reset frame uses pal_sel (toggle not armed).

Source files
------------

// File: rtl/axis_palette_lut_mp.sv
// Multi-palette AXI-Stream colour LUT: unpacks LANES pixel indices per beat, looks each up
// in a per-frame palette of a CPU-loadable RAM, and emits one colour per output beat.
module axis_palette_lut_mp #(
  parameter int unsigned PIX_WIDTH = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned PALETTES  = 4,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                                     axis_aclk,
  input  logic                                     axis_aresetn,
  input  logic [$clog2(PALETTES)-1:0]              pal_sel,
  input  logic                                     toggle_en,
  input  logic [LANES*PIX_WIDTH-1:0]               s_axis_tdata,
  input  logic [LANES-1:0]                         s_axis_tuser,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic [OUT_WIDTH-1:0]                     m_axis_tdata,
  output logic                                     m_axis_tuser,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  input  logic                                     lut_en,
  input  logic                                     lut_we,
  input  logic [$clog2(PALETTES)+PIX_WIDTH-1:0]    lut_addr,
  input  logic [OUT_WIDTH-1:0]                     lut_wdata,
  output logic [OUT_WIDTH-1:0]                     lut_rdata
);

  localparam int unsigned PAL_W  = $clog2(PALETTES);
  localparam int unsigned ADDR_W = PAL_W + PIX_WIDTH;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [OUT_WIDTH-1:0]       mem [0:DEPTH-1];

  logic [LANES*PIX_WIDTH-1:0] hold_data;
  logic [LANES-1:0]           hold_user;
  logic                       hold_valid;
  logic [LANE_W-1:0]          lane;
  logic [PAL_W-1:0]           pal_act;
  logic                       toggle_armed;
  logic [OUT_WIDTH-1:0]       rd_word;
  logic                       s1_valid;
  logic                       s1_user;

  logic                       adv_c;
  logic                       issue_c;
  logic                       last_lane_c;
  logic                       s_fire_c;
  logic [PIX_WIDTH-1:0]       idx_c;
  logic                       sof_c;
  logic [PAL_W-1:0]           pal_new_c;
  logic [PAL_W-1:0]           pal_use_c;
  logic [ADDR_W-1:0]          rd_addr_c;

  assign adv_c       = ~m_axis_tvalid | m_axis_tready;
  assign issue_c     = adv_c & hold_valid;
  assign last_lane_c = (lane == LAST_LANE);
  assign s_axis_tready = axis_aresetn & (~hold_valid | (last_lane_c & adv_c));
  assign s_fire_c    = s_axis_tvalid & s_axis_tready;

  // Select the current lane's index and SOF flag from the holding register
  always_comb begin
    idx_c = '0;
    sof_c = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) begin
        idx_c = hold_data[i*PIX_WIDTH +: PIX_WIDTH];
        sof_c = hold_user[i];
      end
    end
  end

  // The SOF pixel already uses the palette it selects for its frame
  always_comb begin
    pal_new_c = (toggle_en & toggle_armed) ? (pal_act ^ PAL_W'(1)) : pal_sel;
    pal_use_c = sof_c ? pal_new_c : pal_act;
    rd_addr_c = {pal_use_c, idx_c};
  end

  // CPU port write; stream port never writes, so collisions read the old word
  always_ff @(posedge axis_aclk) begin
    if (lut_en && lut_we) begin
      mem[lut_addr] <= lut_wdata;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      lut_rdata <= '0;
    end else if (lut_en) begin
      lut_rdata <= mem[lut_addr];
    end
  end

  // Stream read port, enabled only when the pipeline advances
  always_ff @(posedge axis_aclk) begin
    if (issue_c) begin
      rd_word <= mem[rd_addr_c];
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      hold_data     <= '0;
      hold_user     <= '0;
      hold_valid    <= 1'b0;
      lane          <= '0;
      pal_act       <= '0;
      toggle_armed  <= 1'b0;
      s1_valid      <= 1'b0;
      s1_user       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (s_fire_c) begin
        hold_data  <= s_axis_tdata;
        hold_user  <= s_axis_tuser;
        hold_valid <= 1'b1;
      end else if (issue_c && last_lane_c) begin
        hold_valid <= 1'b0;
      end

      if (issue_c) begin
        lane <= last_lane_c ? '0 : lane + LANE_W'(1);
        if (sof_c) begin
          pal_act      <= pal_new_c;
          toggle_armed <= toggle_en;
        end
      end

      if (adv_c) begin
        s1_valid      <= issue_c;
        s1_user       <= issue_c & sof_c;
        m_axis_tvalid <= s1_valid;
        m_axis_tuser  <= s1_user;
        m_axis_tdata  <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_axis_palette_lut_mp.sv
// Directed bench for axis_palette_lut_mp: palette selection, toggle mode, backpressure,
// LUT port collision/read-first and mid-stream reset.
module tb_axis_palette_lut_mp;

  logic        axis_aclk;
  logic        axis_aresetn;
  logic [1:0]  pal_sel;
  logic        toggle_en;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        lut_en;
  logic        lut_we;
  logic [9:0]  lut_addr;
  logic [31:0] lut_wdata;
  logic [31:0] lut_rdata;

  int checks   = 0;
  int failures = 0;

  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  logic        stab_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  logic        done;

  axis_palette_lut_mp dut (
    .axis_aclk     (axis_aclk),
    .axis_aresetn  (axis_aresetn),
    .pal_sel       (pal_sel),
    .toggle_en     (toggle_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .lut_en        (lut_en),
    .lut_we        (lut_we),
    .lut_addr      (lut_addr),
    .lut_wdata     (lut_wdata),
    .lut_rdata     (lut_rdata)
  );

  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output capture: a transfer happens at the next rising edge when valid & ready at mid-cycle
  always @(negedge axis_aclk) begin
    if (axis_aresetn && m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tuser, m_axis_tdata});
    if (stab_en && axis_aresetn && prev_stall)
      chk("stall_stable", {31'd0, m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {31'd1, prev_word});
    prev_stall = axis_aresetn & m_axis_tvalid & ~m_axis_tready;
    prev_word  = {m_axis_tuser, m_axis_tdata};
  end

  task automatic tick;
    @(posedge axis_aclk);
    #1;
  endtask

  function automatic logic [31:0] pal_word(input int p, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (p)
      0:       pal_word = {8'h00, b, b, b};
      1:       pal_word = 32'h0011_0000 | {24'h0, b};
      2:       pal_word = 32'h00AA_0000 | {24'h0, b};
      default: pal_word = 32'h00BB_0000 | {24'h0, b};
    endcase
  endfunction

  task automatic send_beat(input logic [31:0] data, input logic [3:0] user);
    int n;
    n = 0;
    s_axis_tdata  = data;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 400) begin
      @(posedge axis_aclk);
      #2;
      n++;
    end
    if (!s_axis_tready) begin
      chk("send_timeout", 64'(s_axis_tready), 64'd1);
      s_axis_tvalid = 1'b0;
    end else begin
      @(posedge axis_aclk);
      #1;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic expect_pixel(input string tag, input logic [31:0] d, input logic u);
    int n;
    logic [32:0] w;
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin
      @(posedge axis_aclk);
      #1;
      n++;
    end
    if (obs_q.size() == 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      w = obs_q.pop_front();
      chk(tag, 64'(w), 64'({u, d}));
    end
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] base, input logic [3:0] user);
    for (int l = 0; l < 4; l++)
      expect_pixel($sformatf("%s_l%0d", tag, l), base | 32'(l), user[l]);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [32:0] e;
    axis_aresetn  = 1'b0;
    pal_sel       = 2'd0;
    toggle_en     = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    lut_en        = 1'b0;
    lut_we        = 1'b0;
    lut_addr      = '0;
    lut_wdata     = '0;
    done          = 1'b0;
    repeat (3) tick;

    // Reset state
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_lut_rdata", 64'(lut_rdata), 64'd0);
    axis_aresetn = 1'b1;
    tick;

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        lut_en    = 1'b1;
        lut_we    = 1'b1;
        lut_addr  = 10'((p << 8) | i);
        lut_wdata = pal_word(p, i);
        tick;
      end
    end
    lut_en = 1'b0;
    lut_we = 1'b0;
    tick;

    // 1: basic lookup and latency
    send_beat(32'h0302_0100, 4'b0001);
    @(negedge axis_aclk); chk("t1_valid_e0", 64'(m_axis_tvalid), 64'd0);
    @(negedge axis_aclk); chk("t1_valid_e1", 64'(m_axis_tvalid), 64'd0);
    @(negedge axis_aclk); chk("t1_valid_e2", 64'(m_axis_tvalid), 64'd1);
    @(negedge axis_aclk); chk("t1_valid_e3", 64'(m_axis_tvalid), 64'd1);
    @(negedge axis_aclk); chk("t1_valid_e4", 64'(m_axis_tvalid), 64'd1);
    @(negedge axis_aclk); chk("t1_valid_e5", 64'(m_axis_tvalid), 64'd1);
    @(negedge axis_aclk); chk("t1_valid_e6", 64'(m_axis_tvalid), 64'd0);
    expect_pixel("t1_p0", 32'h0000_0000, 1'b1);
    expect_pixel("t1_p1", 32'h0001_0101, 1'b0);
    expect_pixel("t1_p2", 32'h0002_0202, 1'b0);
    expect_pixel("t1_p3", 32'h0003_0303, 1'b0);
    tick;

    // 2: pal_sel change mid-frame only takes effect at next SOF
    pal_sel = 2'd2;
    send_beat(32'h0706_0504, 4'b0000);
    expect_pixel("t2_p4", 32'h0004_0404, 1'b0);
    expect_pixel("t2_p5", 32'h0005_0505, 1'b0);
    expect_pixel("t2_p6", 32'h0006_0606, 1'b0);
    expect_pixel("t2_p7", 32'h0007_0707, 1'b0);
    send_beat(32'h0807_0605, 4'b0001);
    expect_pixel("t2_sof", 32'h00AA_0005, 1'b1);
    expect_pixel("t2_q1", 32'h00AA_0006, 1'b0);
    expect_pixel("t2_q2", 32'h00AA_0007, 1'b0);
    expect_pixel("t2_q3", 32'h00AA_0008, 1'b0);
    tick;

    // 3: toggle mode alternates 2,3,2,3; then explicit palette 1
    toggle_en = 1'b1;
    send_beat(32'h0302_0100, 4'b0001); expect_frame("t3_f0", 32'h00AA_0000, 4'b0001);
    send_beat(32'h0302_0100, 4'b0001); expect_frame("t3_f1", 32'h00BB_0000, 4'b0001);
    send_beat(32'h0302_0100, 4'b0001); expect_frame("t3_f2", 32'h00AA_0000, 4'b0001);
    send_beat(32'h0302_0100, 4'b0001); expect_frame("t3_f3", 32'h00BB_0000, 4'b0001);
    tick;
    toggle_en = 1'b0;
    pal_sel   = 2'd1;
    send_beat(32'h0302_0100, 4'b0001); expect_frame("t3_f4", 32'h0011_0000, 4'b0001);
    tick;
    // SOF on lane 2 switches palette within the beat
    pal_sel = 2'd3;
    send_beat(32'h0302_0100, 4'b0100);
    expect_pixel("t3_m0", 32'h0011_0000, 1'b0);
    expect_pixel("t3_m1", 32'h0011_0001, 1'b0);
    expect_pixel("t3_m2", 32'h00BB_0002, 1'b1);
    expect_pixel("t3_m3", 32'h00BB_0003, 1'b0);
    tick;

    // 4: random indices under random backpressure, palette 1
    pal_sel = 2'd1;
    stab_en = 1'b1;
    fork
      begin
        for (int b = 0; b < 64; b++) begin
          rnd = $urandom();
          for (int l = 0; l < 4; l++)
            exp_q.push_back({(b == 0 && l == 0), 32'h0011_0000 | {24'h0, rnd[l*8 +: 8]}});
          send_beat(rnd, (b == 0) ? 4'b0001 : 4'b0000);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge axis_aclk);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      expect_pixel("t4_rand", e[31:0], e[32]);
    end
    repeat (4) tick;
    stab_en = 1'b0;
    chk("t4_no_extra", 64'(obs_q.size()), 64'd0);

    // 5: CPU write collides with stream read of the same word
    pal_sel = 2'd0;
    send_beat(32'h0000_0505, 4'b0001);
    lut_en    = 1'b1;
    lut_we    = 1'b1;
    lut_addr  = 10'h005;
    lut_wdata = 32'hDEAD_BEEF;
    tick;
    lut_we = 1'b0;
    @(negedge axis_aclk); chk("t5_read_first", 64'(lut_rdata), 64'h0005_0505);
    tick;
    lut_en = 1'b0;
    @(negedge axis_aclk); chk("t5_readback", 64'(lut_rdata), 64'hDEAD_BEEF);
    tick;
    @(negedge axis_aclk); chk("t5_rdata_hold", 64'(lut_rdata), 64'hDEAD_BEEF);
    expect_pixel("t5_old", 32'h0005_0505, 1'b1);
    expect_pixel("t5_new", 32'hDEAD_BEEF, 1'b0);
    expect_pixel("t5_l2", 32'h0000_0000, 1'b0);
    expect_pixel("t5_l3", 32'h0000_0000, 1'b0);
    tick;

    // 6: reset while output is stalled mid-beat
    toggle_en     = 1'b1;
    pal_sel       = 2'd2;
    m_axis_tready = 1'b0;
    send_beat(32'h0302_0100, 4'b0001);
    repeat (3) tick;
    @(negedge axis_aclk);
    chk("t6_stall_valid", 64'(m_axis_tvalid), 64'd1);
    chk("t6_stall_data", 64'(m_axis_tdata), 64'h00AA_0000);
    axis_aresetn = 1'b0;
    #1;
    chk("t6_tready_in_rst", 64'(s_axis_tready), 64'd0);
    tick;
    @(negedge axis_aclk);
    chk("t6_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("t6_lut_rdata", 64'(lut_rdata), 64'd0);
    chk("t6_s_tready", 64'(s_axis_tready), 64'd0);
    tick;
    axis_aresetn  = 1'b1;
    m_axis_tready = 1'b1;
    tick;
    chk("t6_no_leftover", 64'(obs_q.size()), 64'd0);
    send_beat(32'h0302_0100, 4'b0001);
    expect_frame("t6_post", 32'h00AA_0000, 4'b0001);
    repeat (4) tick;
    chk("t6_no_extra", 64'(obs_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
